tri_vertex_sequencer: RTL and testbench
=======================================

Name: tri_vertex_sequencer

Overview:
Parametrised successor to the fixed two-triangle stimulus generator in front of the triangle rasteriser. Holds a programmable table of up to NUM_TRI triangles of three vertices each and plays them out as nt pulse plus three consecutive vertex cycles. Paces playback with the rasteriser busy handshake, supports one-shot or looping playback and abort, and flags a rasteriser that never acknowledges.

Parameters:
COORD_W, 3, width of each x/y coordinate
NUM_TRI, 2, table depth in triangles (>=1)
ACK_TIMEOUT, 16, cycles to wait in WAIT_FIN for busy to rise before giving up (>=2)
IDX_W, clog2(NUM_TRI) min 1, triangle index width
AW, clog2(3*NUM_TRI), table entry address width

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
cfg_we  in  1  table write strobe
cfg_addr  in  AW  entry address = 3*tri + vertex (vertex 0..2)
cfg_x  in  COORD_W  x value written
cfg_y  in  COORD_W  y value written
tri_cnt  in  IDX_W+1  triangles to play; 0 or >NUM_TRI clamps to NUM_TRI; sampled on start
loop_en  in  1  1 = wrap to triangle 0 after last; sampled on start
start  in  1  begin playback; accepted only in IDLE
abort  in  1  stop playback immediately
busy  in  1  rasteriser busy
nt  out  1  new-triangle strobe, high in V1 cycle only
xo  out  COORD_W  vertex x
yo  out  COORD_W  vertex y
tri_idx  out  IDX_W  triangle currently played
running  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on one-shot completion
ack_err  out  1  sticky: some triangle timed out; cleared on accepted start

Behaviour:
- Reset: state IDLE; nt, xo, yo, tri_idx, done, ack_err, running = 0; all table entries = 0; timer = 0; seen_busy = 0.
- All outputs registered; values shown apply in the cycle the FSM is in that state.
- States (one-hot): IDLE, WAIT_RDY, V1, V2, V3, WAIT_FIN.
- IDLE: start -> WAIT_RDY, with tri_idx <= 0 and ack_err <= 0; latch clamped tri_cnt and loop_en.
- WAIT_RDY: stay while busy=1; busy=0 -> V1.
- V1: nt=1, xo/yo = entry[3*tri_idx+0]. V2: entry +1. V3: entry +2. Transitions are unconditional and busy is ignored during V1..V3.
- V3 -> WAIT_FIN: timer <= 0, seen_busy <= 0.
- WAIT_FIN: busy=1 sets seen_busy; timer increments each cycle.
- WAIT_FIN exits when seen_busy=1 and busy=0, or when timer = ACK_TIMEOUT-1 with seen_busy=0 and busy=0. The timeout exit sets ack_err.
- WAIT_FIN exit, triangle not last: tri_idx+1, go to WAIT_RDY.
- WAIT_FIN exit, last triangle with loop: tri_idx <= 0, go to WAIT_RDY.
- WAIT_FIN exit, last triangle without loop: done=1 for one cycle, go to IDLE.
- xo/yo = 0 and nt = 0 in every state except V1..V3.
- Latency: start sampled at edge k with busy low. WAIT_RDY at k+1, V1 (nt) at k+2, V3 at k+4.
- abort has highest priority: any state -> IDLE at the next edge, outputs zeroed, no done, ack_err kept. abort with start in IDLE: abort wins.
- cfg_we honoured only in IDLE, otherwise dropped. A write and an accepted start in the same cycle: the write lands, and playback uses the new value.
- Reset mid-playback: immediate return to reset values, table cleared.

Decomposition:
- Package tri_seq_pkg: one-hot state constants, vertex offset constants (0,1,2), clamp helper for tri_cnt.
- Sub-module tri_vertex_table: 3*NUM_TRI x (2*COORD_W) register file with async reset clear, one write port and one combinational read port.
- The FSM, timer and output registers stay in the top module.

Test Plan:
- Load tri0 = (1,1),(4,1),(1,7) and tri1 = (1,1),(7,1),(1,3); tri_cnt=2, loop_en=0, start; rasteriser model raises busy 2 cycles after nt and holds it 5 cycles.
  -> nt pulses twice; xo/yo sequences match the loaded values; tri_idx 0 then 1; done pulses once; ack_err=0; running drops.
- Hold busy=1 before start.
  -> FSM stays in WAIT_RDY with nt=0 and xo=0; nt fires 1 cycle after busy falls.
- busy held 0 forever.
  -> each triangle leaves WAIT_FIN after ACK_TIMEOUT cycles; ack_err=1 after the first timeout; done still pulses.
  -> a following start clears ack_err.
- loop_en=1, tri_cnt=2.
  -> tri_idx sequence 0,1,0,1; no done pulse.
  -> abort in V2 gives xo=yo=0 and IDLE on the next cycle, with no done.
- cfg_we during playback writing (7,7) to entry 0.
  -> table unchanged, replay shows (1,1).
- tri_cnt=0 with NUM_TRI=2.
  -> two triangles played.
- Assert reset in V1.
  -> all outputs 0 immediately; table reads 0 on the next playback.

Source files
------------

// File: rtl/tri_seq_pkg.sv
// tri_seq_pkg: shared state encoding, vertex offsets and triangle-count clamp
package tri_seq_pkg;
  localparam logic [5:0] ST_IDLE = 6'b000001;
  localparam logic [5:0] ST_WRDY = 6'b000010;
  localparam logic [5:0] ST_V1   = 6'b000100;
  localparam logic [5:0] ST_V2   = 6'b001000;
  localparam logic [5:0] ST_V3   = 6'b010000;
  localparam logic [5:0] ST_WFIN = 6'b100000;
  localparam int VOFF0 = 0;
  localparam int VOFF1 = 1;
  localparam int VOFF2 = 2;
  function automatic int clamp_cnt(input int cnt, input int depth);
    return (cnt == 0 || cnt > depth) ? depth : cnt;
  endfunction
endpackage

// File: rtl/tri_vertex_table.sv
// tri_vertex_table: vertex register file, one write port and one combinational read port
module tri_vertex_table #(
  parameter int DEPTH = 6,
  parameter int DW    = 6,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);
  logic [DW-1:0] mem_q [DEPTH];
  // table storage, cleared on reset, addresses beyond the table are ignored
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (we_i && int'(wr_addr_i) < DEPTH) mem_q[wr_addr_i] <= wr_data_i;
  assign rd_data_o = (int'(rd_addr_i) < DEPTH) ? mem_q[rd_addr_i] : '0;
endmodule

// File: rtl/tri_vertex_sequencer.sv
// tri_vertex_sequencer: plays a programmable triangle table to the rasteriser, paced by busy
module tri_vertex_sequencer
  import tri_seq_pkg::*;
#(
  parameter int COORD_W     = 3,
  parameter int NUM_TRI     = 2,
  parameter int ACK_TIMEOUT = 16,
  parameter int IDX_W       = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1,
  parameter int AW          = $clog2(3 * NUM_TRI)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic [IDX_W:0]     tri_cnt,
  input  logic               loop_en,
  input  logic               start,
  input  logic               abort,
  input  logic               busy,
  output logic               nt,
  output logic [COORD_W-1:0] xo,
  output logic [COORD_W-1:0] yo,
  output logic [IDX_W-1:0]   tri_idx,
  output logic               running,
  output logic               done,
  output logic               ack_err
);
  localparam int CW = IDX_W + 1;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  logic [5:0] state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic loop_q, loop_d, seen_q, seen_d, err_q, err_d, done_d;
  logic [TW-1:0] timer_q, timer_d;
  logic nt_q, run_q, done_q;
  logic [COORD_W-1:0] xo_q, yo_q;
  logic [AW-1:0] rd_addr;
  logic [2*COORD_W-1:0] rd_data;
  logic last, fin_exit, in_v;
  assign last = (CW'(idx_q) + CW'(1)) == cnt_q;
  assign fin_exit = state_q == ST_WFIN && !busy && (seen_q || timer_q == TW'(ACK_TIMEOUT - 1));
  assign in_v = state_d == ST_V1 || state_d == ST_V2 || state_d == ST_V3;
  assign rd_addr = AW'(3 * int'(idx_d) + (state_d == ST_V3 ? VOFF2 : state_d == ST_V2 ? VOFF1 : VOFF0));
  tri_vertex_table #(.DEPTH(3 * NUM_TRI), .DW(2 * COORD_W), .AW(AW)) u_table (
    .clk      (clk),
    .reset    (reset),
    .we_i     (cfg_we && state_q == ST_IDLE),
    .wr_addr_i(cfg_addr),
    .wr_data_i({cfg_x, cfg_y}),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );
  // playback sequencing: abort first, then start, vertex stepping and acknowledge wait
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    loop_d = loop_q;
    timer_d = timer_q;
    seen_d = seen_q;
    err_d = err_q;
    done_d = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      idx_d = '0;
    end else if (state_q == ST_IDLE && start) begin
      state_d = ST_WRDY;
      idx_d = '0;
      err_d = 1'b0;
      cnt_d = CW'(clamp_cnt(int'(tri_cnt), NUM_TRI));
      loop_d = loop_en;
    end else if (state_q == ST_WRDY && !busy) state_d = ST_V1;
    else if (state_q == ST_V1) state_d = ST_V2;
    else if (state_q == ST_V2) state_d = ST_V3;
    else if (state_q == ST_V3) begin
      state_d = ST_WFIN;
      timer_d = '0;
      seen_d = 1'b0;
    end else if (state_q == ST_WFIN) begin
      timer_d = timer_q + TW'(1);
      seen_d = seen_q | busy;
      if (fin_exit) begin
        err_d = err_q | !seen_q;
        state_d = (last && !loop_q) ? ST_IDLE : ST_WRDY;
        idx_d = last ? '0 : idx_q + IDX_W'(1);
        done_d = last && !loop_q;
      end
    end
  end
  // control state registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      loop_q <= 1'b0;
      timer_q <= '0;
      seen_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      loop_q <= loop_d;
      timer_q <= timer_d;
      seen_q <= seen_d;
      err_q <= err_d;
    end
  // output registers reflect the state being entered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      nt_q <= 1'b0;
      xo_q <= '0;
      yo_q <= '0;
      run_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      nt_q <= state_d == ST_V1;
      xo_q <= in_v ? rd_data[2*COORD_W-1:COORD_W] : '0;
      yo_q <= in_v ? rd_data[COORD_W-1:0] : '0;
      run_q <= state_d != ST_IDLE;
      done_q <= done_d;
    end
  assign nt = nt_q;
  assign xo = xo_q;
  assign yo = yo_q;
  assign tri_idx = idx_q;
  assign running = run_q;
  assign done = done_q;
  assign ack_err = err_q;
endmodule

// File: tb/tb_tri_vertex_sequencer.sv
// tb_tri_vertex_sequencer: directed and randomized playback checked against a table model
module tb_tri_vertex_sequencer;
  logic clk = 1'b0, reset = 1'b1, cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0, cfg_x = '0, cfg_y = '0;
  logic [1:0] tri_cnt = '0;
  logic loop_en = 1'b0, start = 1'b0, abort = 1'b0, busy = 1'b0;
  logic nt, running, done, ack_err;
  logic [2:0] xo, yo;
  logic [0:0] tri_idx;
  int compared = 0, mismatched = 0;
  int tx [6], ty [6];
  always #5 clk = ~clk;
  tri_vertex_sequencer dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .tri_cnt(tri_cnt), .loop_en(loop_en), .start(start), .abort(abort), .busy(busy),
    .nt(nt), .xo(xo), .yo(yo), .tri_idx(tri_idx), .running(running), .done(done), .ack_err(ack_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int eff(input int tc);
    return (tc == 0 || tc > 2) ? 2 : tc;
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_nt"}, nt, 0);
    chk({tag, "_xo"}, xo, 0);
    chk({tag, "_yo"}, yo, 0);
    chk({tag, "_idx"}, tri_idx, 0);
    chk({tag, "_run"}, running, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, ack_err, 0);
  endtask
  task automatic wr_entry(input int a, input int x, input int y);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_x = 3'(x); cfg_y = 3'(y);
    @(negedge clk);
    cfg_we = 1'b0;
    tx[a] = x; ty[a] = y;
  endtask
  task automatic do_start(input int tc, input bit lp, input bit wr, input int wx, input int wy);
    @(negedge clk);
    tri_cnt = 2'(tc); loop_en = lp; start = 1'b1;
    if (wr) begin
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_x = 3'(wx); cfg_y = 3'(wy);
      tx[0] = wx; ty[0] = wy;
    end
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    chk("start_running", running, 1);
    chk("start_err_clr", ack_err, 0);
    chk("start_nt_low", nt, 0);
  endtask
  // mode 0: rasteriser acknowledges each triangle; mode 1: busy never rises
  task automatic play(input int tc, input int mode, input int stop_n, input bit wr_mid,
                      input int budget, output int got, output int dones);
    int since, v, cur, last_nt, n;
    since = -1; v = -1; cur = 0; last_nt = -1; n = eff(tc);
    got = 0; dones = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      if (done) dones++;
      if (nt) begin
        if (got == 0) chk("first_nt_latency", c, 0);
        cur = got % n;
        chk("tri_idx", tri_idx, cur);
        chk("err_at_nt", ack_err, (mode == 1 && got > 0) ? 1 : 0);
        if (mode == 1 && got > 0) chk("timeout_gap", c - last_nt, 20);
        last_nt = c; got++; v = 0; since = 0;
      end else if (since >= 0) since++;
      if (v >= 0 && v < 3) begin
        chk("vx", xo, tx[3*cur+v]);
        chk("vy", yo, ty[3*cur+v]);
        v++;
      end else begin
        chk("gap_xo", xo, 0);
        chk("gap_yo", yo, 0);
      end
      busy = (mode == 0) && since >= 1 && since <= 5;
      if (wr_mid && got == 1 && v == 1) begin
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_x = 3'd7; cfg_y = 3'd7;
      end
      if (stop_n > 0 && got == stop_n && v == 1) break;
      if (stop_n == 0 && got > 0 && !running) break;
    end
    busy = 1'b0;
  endtask
  initial begin
    int got, dones, found, tc;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    wr_entry(0, 1, 1); wr_entry(1, 4, 1); wr_entry(2, 1, 7);
    wr_entry(3, 1, 1); wr_entry(4, 7, 1); wr_entry(5, 1, 3);
    do_start(2, 0, 0, 0, 0);
    play(2, 0, 0, 0, 200, got, dones);
    chk("oneshot_tris", got, 2);
    chk("oneshot_done", dones, 1);
    chk("oneshot_err", ack_err, 0);
    chk("oneshot_running", running, 0);
    busy = 1'b1;
    do_start(1, 0, 0, 0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_nt", nt, 0);
      chk("hold_xo", xo, 0);
      chk("hold_running", running, 1);
    end
    busy = 1'b0;
    play(1, 0, 0, 0, 100, got, dones);
    chk("hold_tris", got, 1);
    chk("hold_done", dones, 1);
    do_start(2, 0, 0, 0, 0);
    play(2, 1, 0, 0, 200, got, dones);
    chk("timeout_tris", got, 2);
    chk("timeout_done", dones, 1);
    chk("timeout_err", ack_err, 1);
    do_start(2, 0, 0, 0, 0);
    play(2, 0, 0, 0, 200, got, dones);
    chk("after_err_tris", got, 2);
    do_start(2, 1, 0, 0, 0);
    play(2, 0, 4, 0, 300, got, dones);
    chk("loop_tris", got, 4);
    chk("loop_no_done", dones, 0);
    @(negedge clk);
    chk("abort_v2_x", xo, tx[4]);
    chk("abort_v2_y", yo, ty[4]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_xo", xo, 0);
    chk("abort_yo", yo, 0);
    chk("abort_nt", nt, 0);
    chk("abort_running", running, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    chk("abort_done_late", done, 0);
    do_start(1, 0, 0, 0, 0);
    play(1, 0, 0, 1, 100, got, dones);
    chk("wr_mid_tris", got, 1);
    do_start(1, 0, 0, 0, 0);
    play(1, 0, 0, 0, 100, got, dones);
    chk("replay_tris", got, 1);
    do_start(0, 0, 0, 0, 0);
    play(0, 0, 0, 0, 200, got, dones);
    chk("cnt0_tris", got, 2);
    chk("cnt0_done", dones, 1);
    repeat (4) begin
      for (int a = 0; a < 6; a++) wr_entry(a, $urandom_range(0, 7), $urandom_range(0, 7));
      tc = $urandom_range(0, 3);
      do_start(tc, 0, 1, $urandom_range(0, 7), $urandom_range(0, 7));
      play(tc, 0, 0, 0, 200, got, dones);
      chk("rand_tris", got, eff(tc));
      chk("rand_done", dones, 1);
    end
    do_start(2, 0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (nt) begin
        found = 1;
        break;
      end
    end
    chk("v1_found", found, 1);
    reset = 1'b1;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 6; a++) begin
      tx[a] = 0; ty[a] = 0;
    end
    do_start(2, 0, 0, 0, 0);
    play(2, 0, 0, 0, 200, got, dones);
    chk("cleared_tris", got, 2);
    chk("cleared_done", dones, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
